// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, memory port and stalls.
// master = arbiter view, slave = pipeline/memory view.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ack;

   logic          d_req;
   logic          d_we;
   logic          d_size;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;

   logic          m_req;
   logic          m_we;
   logic          m_size;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack;

   logic          stall_if;
   logic          stall_mem;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata, m_ack,
      output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_size, m_addr, m_wdata,
             stall_if, stall_mem
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata, m_ack,
      input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_size, m_addr, m_wdata,
             stall_if, stall_mem
   );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port variable-latency memory.
// Optional macro ARB_PERF_EN enables the saturating stall-cycle counters.
module mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_LIM = 4,
   parameter int CW         = 3
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus,
   output logic [31:0]   perf_i_wait,
   output logic [31:0]   perf_d_wait
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

   state_t        state;
   state_t        state_nxt;
   logic          grant_i;
   logic          grant_d;
   logic [CW-1:0] streak;
   logic          squash;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Data wins ties unless fetch has already lost STARVE_LIM times in a row.
   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.d_req && !(bus.i_req && streak == CW'(STARVE_LIM))) begin
               grant_d   = 1'b1;
               state_nxt = BUSY_D;
            end else if (bus.i_req) begin
               grant_i   = 1'b1;
               state_nxt = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: if (bus.m_ack) state_nxt = RESP;
         RESP:           state_nxt = IDLE;
         default:        state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak      <= '0;
         squash      <= 1'b0;
         bus.i_ack   <= 1'b0;
         bus.d_ack   <= 1'b0;
         bus.i_rdata <= {DW{1'b0}};
         bus.d_rdata <= {DW{1'b0}};
         bus.m_req   <= 1'b0;
         bus.m_we    <= 1'b0;
         bus.m_size  <= 1'b0;
         bus.m_addr  <= {AW{1'b0}};
         bus.m_wdata <= {DW{1'b0}};
      end else begin
         bus.i_ack <= 1'b0;
         bus.d_ack <= 1'b0;

         if (!bus.i_req || grant_i) streak <= '0;
         else if (grant_d)          streak <= streak + 1'b1;

         if (grant_d) begin
            bus.m_req   <= 1'b1;
            bus.m_we    <= bus.d_we;
            bus.m_size  <= bus.d_size;
            bus.m_addr  <= bus.d_addr;
            bus.m_wdata <= bus.d_wdata;
         end
         if (grant_i) begin
            bus.m_req   <= 1'b1;
            bus.m_we    <= 1'b0;
            bus.m_size  <= 1'b0;
            bus.m_addr  <= bus.i_addr;
            bus.m_wdata <= {DW{1'b0}};
         end

         // A withdrawn fetch still finishes on memory but is never acknowledged.
         if (state == BUSY_I && !bus.i_req) squash <= 1'b1;
         if (state == RESP)                 squash <= 1'b0;

         if (bus.m_ack && state == BUSY_I) begin
            bus.m_req <= 1'b0;
            if (!squash && bus.i_req) begin
               bus.i_rdata <= bus.m_rdata;
               bus.i_ack   <= 1'b1;
            end
         end
         if (bus.m_ack && state == BUSY_D) begin
            bus.m_req <= 1'b0;
            bus.d_ack <= 1'b1;
            if (!bus.m_we) bus.d_rdata <= bus.m_rdata;
         end
      end
   end

   assign bus.stall_if  = bus.i_req & ~bus.i_ack;
   assign bus.stall_mem = bus.d_req & ~bus.d_ack;

`ifdef ARB_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_i_wait <= 32'd0;
         perf_d_wait <= 32'd0;
      end else begin
         if (bus.stall_if && perf_i_wait != 32'hFFFF_FFFF)  perf_i_wait <= perf_i_wait + 32'd1;
         if (bus.stall_mem && perf_d_wait != 32'hFFFF_FFFF) perf_d_wait <= perf_d_wait + 32'd1;
      end
   end
`else
   assign perf_i_wait = 32'd0;
   assign perf_d_wait = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int STARVE_LIM = 4;
   localparam int CW = 3;
`ifdef ARB_PERF_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] perf_i_wait;
   logic [31:0] perf_d_wait;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(STARVE_LIM), .CW(CW)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait)
   );

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.m_ack = 1'b0; bus.m_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      sample();
      n_cmp++;
      if ({bus.i_ack, bus.d_ack, bus.m_req, bus.m_we, bus.m_size} !== 5'b0) begin
         n_err++; $display("FAIL reset_ctrl got=%b want=00000", {bus.i_ack, bus.d_ack, bus.m_req, bus.m_we, bus.m_size});
      end
      n_cmp++;
      if ({bus.i_rdata, bus.d_rdata, bus.m_addr, bus.m_wdata, perf_i_wait, perf_d_wait} !== 192'd0) begin
         n_err++; $display("FAIL reset_data got=%h want=0", {bus.i_rdata, bus.d_rdata, bus.m_addr, bus.m_wdata});
      end
      step();
      rst = 1'b0;
      bus.d_req = 1'b1; bus.d_addr = 32'h40;
      step();
      sample();
      n_cmp++;
      if (bus.m_req !== 1'b1) begin n_err++; $display("FAIL reset_busy_mreq got=%b want=1", bus.m_req); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.m_req !== 1'b0) begin n_err++; $display("FAIL reset_async_mreq got=%b want=0", bus.m_req); end
      step();
      sample();
      n_cmp++;
      if ({bus.i_ack, bus.d_ack, bus.m_req, bus.m_addr} !== 35'd0) begin
         n_err++; $display("FAIL reset_mid_all got=%h want=0", {bus.i_ack, bus.d_ack, bus.m_req, bus.m_addr});
      end
      step();
      rst = 1'b0;
      idle_inputs();
      bus.i_req = 1'b1; bus.i_addr = 32'h0;
      sample();
      n_cmp++;
      if (bus.m_req !== 1'b0) begin n_err++; $display("FAIL reset_after_c0_mreq got=%b want=0", bus.m_req); end
      step();
      sample();
      n_cmp++;
      if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h0}) begin
         n_err++; $display("FAIL reset_after_fetch got=%h want=100000000", {bus.m_req, bus.m_addr});
      end
   endtask

   task automatic test_fetch();
      do_reset();
      bus.i_req = 1'b1; bus.i_addr = 32'h4;
      sample();
      n_cmp++;
      if ({bus.stall_if, bus.m_req, bus.i_ack} !== 3'b100) begin
         n_err++; $display("FAIL fetch_c0 got=%b want=100", {bus.stall_if, bus.m_req, bus.i_ack});
      end
      step();
      bus.m_ack = 1'b1; bus.m_rdata = 32'h2001_0005;
      sample();
      n_cmp++;
      if ({bus.stall_if, bus.m_req, bus.i_ack, bus.m_we, bus.m_size, bus.m_addr} !== {5'b11000, 32'h4}) begin
         n_err++; $display("FAIL fetch_c1 got=%h want=%h", {bus.stall_if, bus.m_req, bus.i_ack, bus.m_we, bus.m_size, bus.m_addr}, {5'b11000, 32'h4});
      end
      step();
      bus.m_ack = 1'b0; bus.m_rdata = 32'hFFFF_FFFF;
      sample();
      n_cmp++;
      if ({bus.i_ack, bus.stall_if, bus.m_req} !== 3'b100) begin
         n_err++; $display("FAIL fetch_c2_ack got=%b want=100", {bus.i_ack, bus.stall_if, bus.m_req});
      end
      n_cmp++;
      if (bus.i_rdata !== 32'h2001_0005) begin n_err++; $display("FAIL fetch_rdata got=%h want=20010005", bus.i_rdata); end
      step();
      bus.i_req = 1'b0;
      sample();
      n_cmp++;
      if (bus.i_ack !== 1'b0) begin n_err++; $display("FAIL fetch_ack_pulse got=%b want=0", bus.i_ack); end
   endtask

   task automatic test_priority();
      step();
      bus.i_req = 1'b1; bus.i_addr = 32'h8;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 1'b0; bus.d_addr = 32'h100;
      step();
      bus.m_ack = 1'b1; bus.m_rdata = 32'hDEAD_0100;
      sample();
      n_cmp++;
      if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL prio_first got=%h want=100000100", {bus.m_req, bus.m_addr}); end
      step();
      bus.m_ack = 1'b0;
      sample();
      n_cmp++;
      if ({bus.d_ack, bus.i_ack, bus.d_rdata} !== {2'b10, 32'hDEAD_0100}) begin
         n_err++; $display("FAIL prio_dack got=%h want=%h", {bus.d_ack, bus.i_ack, bus.d_rdata}, {2'b10, 32'hDEAD_0100});
      end
      step();
      bus.d_req = 1'b0;
      sample();
      n_cmp++;
      if ({bus.m_req, bus.d_ack, bus.i_ack} !== 3'b000) begin n_err++; $display("FAIL prio_idle got=%b want=000", {bus.m_req, bus.d_ack, bus.i_ack}); end
      step();
      bus.m_ack = 1'b1; bus.m_rdata = 32'h1111_0008;
      sample();
      n_cmp++;
      if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h8}) begin n_err++; $display("FAIL prio_second got=%h want=100000008", {bus.m_req, bus.m_addr}); end
      step();
      bus.m_ack = 1'b0;
      sample();
      n_cmp++;
      if ({bus.i_ack, bus.d_ack, bus.i_rdata} !== {2'b10, 32'h1111_0008}) begin
         n_err++; $display("FAIL prio_iack got=%h want=%h", {bus.i_ack, bus.d_ack, bus.i_rdata}, {2'b10, 32'h1111_0008});
      end
      step();
      bus.i_req = 1'b0;
   endtask

   task automatic test_starvation();
      bit got_i[10];
      int ng = 0;
      int s = 0;
      logic prev = 1'b0;
      do_reset();
      bus.i_req = 1'b1; bus.i_addr = 32'h1000;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000;
      for (int cyc = 0; cyc < 200 && ng < 10; cyc++) begin
         step();
         bus.m_ack = bus.m_req;
         bus.m_rdata = cyc;
         sample();
         if (bus.m_req && !prev) begin
            got_i[ng] = (bus.m_addr == 32'h1000);
            ng++;
         end
         prev = bus.m_req;
         n_cmp++;
         if (bus.i_ack && bus.d_ack) begin n_err++; $display("FAIL starve_ack_overlap got=11 want=not both"); end
      end
      n_cmp++;
      if (ng != 10) begin n_err++; $display("FAIL starve_timeout got=%0d grants want=10", ng); end
      for (int k = 0; k < ng; k++) begin
         bit exp_i;
         exp_i = (s == STARVE_LIM);
         s = exp_i ? 0 : s + 1;
         n_cmp++;
         if (got_i[k] !== exp_i) begin n_err++; $display("FAIL starve_order[%0d] got_fetch=%b want_fetch=%b", k, got_i[k], exp_i); end
      end
   endtask

   task automatic test_flush();
      do_reset();
      bus.i_req = 1'b1; bus.i_addr = 32'hC;
      step();
      bus.i_req = 1'b0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
      sample();
      n_cmp++;
      if ({bus.m_req, bus.m_addr} !== {1'b1, 32'hC}) begin n_err++; $display("FAIL flush_busy got=%h want=10000000c", {bus.m_req, bus.m_addr}); end
      step();
      sample();
      n_cmp++;
      if (bus.m_req !== 1'b1) begin n_err++; $display("FAIL flush_wait_mreq got=%b want=1", bus.m_req); end
      step();
      bus.m_ack = 1'b1; bus.m_rdata = 32'hBAD0_BAD0;
      step();
      bus.m_ack = 1'b0;
      sample();
      n_cmp++;
      if ({bus.i_ack, bus.d_ack, bus.i_rdata} !== 34'd0) begin
         n_err++; $display("FAIL flush_resp got=%h want=0", {bus.i_ack, bus.d_ack, bus.i_rdata});
      end
      step();
      sample();
      n_cmp++;
      if ({bus.m_req, bus.i_ack} !== 2'b00) begin n_err++; $display("FAIL flush_idle got=%b want=00", {bus.m_req, bus.i_ack}); end
      step();
      bus.m_ack = 1'b1; bus.m_rdata = 32'h77;
      sample();
      n_cmp++;
      if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL flush_dgrant got=%h want=100000200", {bus.m_req, bus.m_addr}); end
      step();
      bus.m_ack = 1'b0;
      sample();
      n_cmp++;
      if ({bus.d_ack, bus.i_ack, bus.d_rdata, bus.i_rdata} !== {2'b10, 32'h77, 32'h0}) begin
         n_err++; $display("FAIL flush_dack got=%h want=%h", {bus.d_ack, bus.i_ack, bus.d_rdata, bus.i_rdata}, {2'b10, 32'h77, 32'h0});
      end
      step();
      bus.d_req = 1'b0;
   endtask

   task automatic test_store();
      do_reset();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 1'b0; bus.d_addr = 32'h10;
      step();
      bus.m_ack = 1'b1; bus.m_rdata = 32'h5A5A_1234;
      step();
      bus.m_ack = 1'b0;
      sample();
      n_cmp++;
      if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'h5A5A_1234}) begin n_err++; $display("FAIL store_preload got=%h want=15a5a1234", {bus.d_ack, bus.d_rdata}); end
      step();
      bus.d_req = 1'b0;
      step();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 1'b1; bus.d_addr = 32'h7; bus.d_wdata = 32'hAB;
      step();
      bus.m_ack = 1'b1; bus.m_rdata = 32'hFFFF_0000;
      sample();
      n_cmp++;
      if ({bus.m_req, bus.m_we, bus.m_size, bus.m_addr, bus.m_wdata} !== {3'b111, 32'h7, 32'hAB}) begin
         n_err++; $display("FAIL store_mbus got=%h want=%h", {bus.m_req, bus.m_we, bus.m_size, bus.m_addr, bus.m_wdata}, {3'b111, 32'h7, 32'hAB});
      end
      step();
      bus.m_ack = 1'b0;
      sample();
      n_cmp++;
      if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'h5A5A_1234}) begin n_err++; $display("FAIL store_ack_rdata got=%h want=15a5a1234", {bus.d_ack, bus.d_rdata}); end
      step();
      bus.d_req = 1'b0;
      sample();
      n_cmp++;
      if ({perf_i_wait, perf_d_wait} !== {32'd0, PERF_ON ? 32'd4 : 32'd0}) begin
         n_err++; $display("FAIL store_perf got=%0d/%0d want=0/%0d", perf_i_wait, perf_d_wait, PERF_ON ? 4 : 0);
      end
   endtask

   task automatic test_random();
      bit          busy = 0, own_i = 0, sq = 0, resp_i = 0, resp_sq = 0, r_we = 0;
      bit          seen_i_ack = 0, seen_d_ack = 0, txn_open = 0, acked = 0;
      bit          exp_i_ack, exp_d_ack, exp_mreq, pick_d, granted;
      int          grant_c = 0, resp_c = -10, next_free = 0, streak = 0, lat_left = 0;
      logic [31:0] g_addr = 0, g_wdata = 0, r_addr = 0, exp_i_rdata = 0, exp_d_rdata = 0, pi = 0, pd = 0;
      bit          g_we = 0, g_size = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         step();
         // requesters
         if (seen_i_ack) begin
            bus.i_req = ($urandom_range(0, 9) < 7); bus.i_addr = $urandom & 32'hFFFF_FFFC;
         end else if (bus.i_req) begin
            if ($urandom_range(0, 19) == 0) bus.i_req = 1'b0;
         end else if ($urandom_range(0, 9) < 4) begin
            bus.i_req = 1'b1; bus.i_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (seen_d_ack || (!bus.d_req && $urandom_range(0, 9) < 3)) begin
            bus.d_req = seen_d_ack ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.d_we = 1'($urandom_range(0, 1)); bus.d_size = 1'($urandom_range(0, 1));
            bus.d_addr = $urandom; bus.d_wdata = $urandom;
         end
         // memory responder, latency 0..3 cycles after m_req rises
         bus.m_ack = 1'b0; bus.m_rdata = $urandom;
         if (bus.m_req) begin
            if (!txn_open) begin txn_open = 1; lat_left = $urandom_range(0, 3); end
            if (lat_left == 0 && !acked) begin
               bus.m_ack = 1'b1; bus.m_rdata = mem_fn(bus.m_addr); acked = 1;
            end else if (lat_left > 0) lat_left--;
         end else begin
            txn_open = 0; acked = 0;
         end
         // reference model
         exp_i_ack = (c == resp_c) && resp_i && !resp_sq;
         exp_d_ack = (c == resp_c) && !resp_i;
         if (exp_i_ack) exp_i_rdata = mem_fn(r_addr);
         if (exp_d_ack && !r_we) exp_d_rdata = mem_fn(r_addr);
         exp_mreq = busy && (c > grant_c);
         if (exp_mreq && own_i && !bus.i_req) sq = 1;
         if (exp_mreq && bus.m_ack) begin
            resp_c = c + 1; resp_i = own_i; resp_sq = sq; r_addr = g_addr; r_we = g_we;
            next_free = c + 2; busy = 0; sq = 0;
         end
         granted = 0;
         if (!busy && c >= next_free && (bus.i_req || bus.d_req)) begin
            pick_d = bus.d_req && !(bus.i_req && streak == STARVE_LIM);
            busy = 1; granted = 1; grant_c = c; own_i = !pick_d;
            g_addr = pick_d ? bus.d_addr : bus.i_addr;
            g_we = pick_d && bus.d_we; g_size = pick_d && bus.d_size; g_wdata = bus.d_wdata;
         end
         if (!bus.i_req || (granted && own_i)) streak = 0;
         else if (granted) streak++;
         sample();
         n_cmp++;
         if ({bus.i_ack, bus.d_ack} !== {exp_i_ack, exp_d_ack}) begin
            n_err++; $display("FAIL rnd_acks c=%0d got=%b%b want=%b%b", c, bus.i_ack, bus.d_ack, exp_i_ack, exp_d_ack);
         end
         n_cmp++;
         if (bus.m_req !== exp_mreq) begin n_err++; $display("FAIL rnd_mreq c=%0d got=%b want=%b", c, bus.m_req, exp_mreq); end
         if (exp_mreq) begin
            n_cmp++;
            if ({bus.m_addr, bus.m_we, bus.m_size} !== {g_addr, g_we, g_size} || (!own_i && bus.m_wdata !== g_wdata)) begin
               n_err++; $display("FAIL rnd_mbus c=%0d got=%h/%b%b/%h want=%h/%b%b/%h", c, bus.m_addr, bus.m_we, bus.m_size, bus.m_wdata, g_addr, g_we, g_size, g_wdata);
            end
         end
         n_cmp++;
         if ({bus.i_rdata, bus.d_rdata} !== {exp_i_rdata, exp_d_rdata}) begin
            n_err++; $display("FAIL rnd_rdata c=%0d got=%h/%h want=%h/%h", c, bus.i_rdata, bus.d_rdata, exp_i_rdata, exp_d_rdata);
         end
         n_cmp++;
         if ({bus.stall_if, bus.stall_mem} !== {bus.i_req && !exp_i_ack, bus.d_req && !exp_d_ack}) begin
            n_err++; $display("FAIL rnd_stall c=%0d got=%b%b want=%b%b", c, bus.stall_if, bus.stall_mem, bus.i_req && !exp_i_ack, bus.d_req && !exp_d_ack);
         end
         n_cmp++;
         if ({perf_i_wait, perf_d_wait} !== (PERF_ON ? {pi, pd} : 64'd0)) begin
            n_err++; $display("FAIL rnd_perf c=%0d got=%0d/%0d want=%0d/%0d", c, perf_i_wait, perf_d_wait, PERF_ON ? pi : 0, PERF_ON ? pd : 0);
         end
         pi += 32'(bus.i_req && !exp_i_ack);
         pd += 32'(bus.d_req && !exp_d_ack);
         seen_i_ack = bus.i_ack;
         seen_d_ack = bus.d_ack;
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_fetch();
      test_priority();
      test_starvation();
      test_flush();
      test_store();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
